// File: rtl/depacketizer.sv
// ============================================================================
// depacketizer
// ----------------------------------------------------------------------------
// Receive-side packet deframer. Takes hard-decision demodulated symbols (one
// per valid cycle) and locks onto a 320-symbol BPSK header. The header is
// 224 alternating symbols starting with 0, then 32 alternating symbols
// starting with 1 (the phase flip), then an 8-symbol mod-ID, a 16-bit
// payload length (MSB first) and 40 alternating tail symbols. Once the
// header decodes cleanly, exactly the payload symbols are forwarded as an
// AXI-Stream packet, and the last one carries tlast.
//
// Optional feature: define POLARITY_AUTO_EN to let the search state lock on
// an inverted preamble as well. The stream is then polarity-corrected until
// the next return to search.
//
// Ports
//   clk              symbol-rate clock
//   rst_n            asynchronous active-low reset
//   i_in_tdata       demodulated symbol; bit0 = BPSK decision
//   i_in_tvalid      symbol valid
//   o_in_tready      1 whenever out of reset (never stalls the demodulator)
//   o_out_tdata      payload symbol, polarity-corrected, latency 1
//   o_out_tvalid     payload symbol valid (single cycle, no buffering)
//   i_out_tready     downstream ready
//   o_out_tlast      last payload symbol of the packet
//   o_out_tuser      1 when the packet is BPSK
//   o_hdr_vld        1-cycle pulse: header decoded OK
//   o_payload_length decoded length in bits, held until the next o_hdr_vld
//   o_hdr_err        1-cycle pulse: bad mod-ID, bad length, or timeout
//   o_pkt_done       1-cycle pulse issued together with o_out_tlast
//   o_ovf            sticky: a symbol overwrote an unaccepted one
// ============================================================================
module depacketizer #(
    parameter int BYTES    = 1,
    parameter int SYNC_MIN = 64,
    parameter int MAX_LEN  = 4096,
    parameter int TIMEOUT  = 1023
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BYTES*8-1:0] i_in_tdata,
    input  logic               i_in_tvalid,
    output logic               o_in_tready,
    output logic [BYTES*8-1:0] o_out_tdata,
    output logic               o_out_tvalid,
    input  logic               i_out_tready,
    output logic               o_out_tlast,
    output logic               o_out_tuser,
    output logic               o_hdr_vld,
    output logic [15:0]        o_payload_length,
    output logic               o_hdr_err,
    output logic               o_pkt_done,
    output logic               o_ovf
);

    localparam int              W          = BYTES * 8;
    localparam logic [7:0]      SYNC_MIN_W = 8'(SYNC_MIN);
    localparam logic [15:0]     MAX_LEN_W  = 16'(MAX_LEN);
    localparam logic [9:0]      TIMEOUT_W  = 10'(TIMEOUT);

    typedef enum logic [2:0] {
        S_SRCH = 3'd0,
        S_FLIP = 3'd1,
        S_MOD  = 3'd2,
        S_LEN  = 3'd3,
        S_TAIL = 3'd4,
        S_PLD  = 3'd5
    } state_t;

    state_t      r_state;
    logic [7:0]  r_alt_cnt;
    logic [5:0]  r_cnt;
    logic [3:0]  r_matches;
    logic        r_prev_b;
    logic        r_is_bpsk;
    logic [15:0] r_len_sr;
    logic [15:0] r_sym_tot;
    logic [15:0] r_pld_cnt;
    logic [9:0]  r_idle_cnt;
`ifdef POLARITY_AUTO_EN
    logic        r_inv;
`endif

    logic         w_inv;
    logic         w_b;
    logic [W-1:0] w_inv_mask;
    logic         w_pat_hit;
    logic [3:0]   w_match_tot;
    logic [9:0]   w_idle_nxt;
    logic [15:0]  w_sym_tot;
    logic         w_len_bad;
    logic         w_last_pld;

    // Polarity-corrected decision and the per-symbol quantities the FSM needs
    always_comb begin
`ifdef POLARITY_AUTO_EN
        // Search always looks at the raw stream; correction starts at the flip.
        if (r_state == S_SRCH) begin
            w_inv = 1'b0;
        end else begin
            w_inv = r_inv;
        end
`else
        w_inv = 1'b0;
`endif
        w_b         = i_in_tdata[0] ^ w_inv;
        w_inv_mask  = {W{w_inv}};
        // BPSK mod-ID is 1,0,1,0,... so symbol k is expected to be ~k[0]
        w_pat_hit   = (w_b == ~r_cnt[0]);
        w_match_tot = r_matches + {3'b000, w_pat_hit};
        w_idle_nxt  = r_idle_cnt + 10'd1;
        if (r_is_bpsk) begin
            w_sym_tot = r_len_sr;
        end else begin
            w_sym_tot = {1'b0, r_len_sr[15:1]};
        end
        // A QPSK length of 1 bit yields zero symbols and is rejected too
        w_len_bad   = (r_len_sr == 16'd0) || (r_len_sr > MAX_LEN_W) || (w_sym_tot == 16'd0);
        w_last_pld  = (r_pld_cnt == (r_sym_tot - 16'd1));
    end

    // Header-lock FSM with all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_SRCH;
            r_alt_cnt        <= 8'd0;
            r_cnt            <= 6'd0;
            r_matches        <= 4'd0;
            r_prev_b         <= 1'b0;
            r_is_bpsk        <= 1'b0;
            r_len_sr         <= 16'd0;
            r_sym_tot        <= 16'd0;
            r_pld_cnt        <= 16'd0;
            r_idle_cnt       <= 10'd0;
`ifdef POLARITY_AUTO_EN
            r_inv            <= 1'b0;
`endif
            o_in_tready      <= 1'b0;
            o_out_tdata      <= {W{1'b0}};
            o_out_tvalid     <= 1'b0;
            o_out_tlast      <= 1'b0;
            o_out_tuser      <= 1'b0;
            o_hdr_vld        <= 1'b0;
            o_payload_length <= 16'd0;
            o_hdr_err        <= 1'b0;
            o_pkt_done       <= 1'b0;
            o_ovf            <= 1'b0;
        end else begin
            o_in_tready  <= 1'b1;
            o_hdr_vld    <= 1'b0;
            o_hdr_err    <= 1'b0;
            o_pkt_done   <= 1'b0;
            // No output buffering: valid lasts exactly one cycle per symbol
            o_out_tvalid <= 1'b0;
            o_out_tlast  <= 1'b0;
`ifdef POLARITY_AUTO_EN
            if (r_state == S_SRCH) begin
                r_inv <= 1'b0;
            end
`endif
            if ((r_state != S_SRCH) && !i_in_tvalid) begin
                // Starved inside a packet: give up after TIMEOUT idle cycles
                if (w_idle_nxt == TIMEOUT_W) begin
                    o_hdr_err  <= 1'b1;
                    r_state    <= S_SRCH;
                    r_alt_cnt  <= 8'd0;
                    r_idle_cnt <= 10'd0;
                end else begin
                    r_idle_cnt <= w_idle_nxt;
                end
            end else if (i_in_tvalid) begin
                r_idle_cnt <= 10'd0;
                r_prev_b   <= w_b;
                case (r_state)
                    S_SRCH: begin
                        if (w_b != r_prev_b) begin
                            if (r_alt_cnt != 8'hFF) begin
                                r_alt_cnt <= r_alt_cnt + 8'd1;
                            end
                        end else if (w_b && (r_alt_cnt >= SYNC_MIN_W)) begin
                            // 1,1 repeat after enough preamble: phase flip
                            r_state  <= S_FLIP;
                            r_cnt    <= 6'd1;
                            r_prev_b <= 1'b1;
                        end
`ifdef POLARITY_AUTO_EN
                        else if (!w_b && (r_alt_cnt >= SYNC_MIN_W)) begin
                            // 0,0 repeat: the same flip seen through an inverted
                            // channel; record the corrected symbol as 1
                            r_state  <= S_FLIP;
                            r_cnt    <= 6'd1;
                            r_prev_b <= 1'b1;
                            r_inv    <= 1'b1;
                        end
`endif
                        else begin
                            r_alt_cnt <= 8'd0;
                        end
                    end
                    S_FLIP: begin
                        if (w_b == r_prev_b) begin
                            r_state   <= S_SRCH;
                            r_alt_cnt <= 8'd0;
                        end else if (r_cnt == 6'd31) begin
                            r_state   <= S_MOD;
                            r_cnt     <= 6'd0;
                            r_matches <= 4'd0;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                    S_MOD: begin
                        if (r_cnt == 6'd7) begin
                            r_cnt <= 6'd0;
                            if (w_match_tot >= 4'd5) begin
                                r_is_bpsk <= 1'b1;
                                r_state   <= S_LEN;
                            end else if (w_match_tot <= 4'd3) begin
                                r_is_bpsk <= 1'b0;
                                r_state   <= S_LEN;
                            end else begin
                                o_hdr_err <= 1'b1;
                                r_state   <= S_SRCH;
                                r_alt_cnt <= 8'd0;
                            end
                        end else begin
                            r_matches <= w_match_tot;
                            r_cnt     <= r_cnt + 6'd1;
                        end
                    end
                    S_LEN: begin
                        r_len_sr <= {r_len_sr[14:0], w_b};
                        if (r_cnt == 6'd15) begin
                            r_cnt   <= 6'd0;
                            r_state <= S_TAIL;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                    S_TAIL: begin
                        if (r_cnt == 6'd39) begin
                            r_cnt <= 6'd0;
                            if (w_len_bad) begin
                                o_hdr_err <= 1'b1;
                                r_state   <= S_SRCH;
                                r_alt_cnt <= 8'd0;
                            end else begin
                                o_hdr_vld        <= 1'b1;
                                o_payload_length <= r_len_sr;
                                o_ovf            <= 1'b0;
                                r_sym_tot        <= w_sym_tot;
                                r_pld_cnt        <= 16'd0;
                                r_state          <= S_PLD;
                            end
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                    S_PLD: begin
                        o_out_tdata  <= i_in_tdata ^ w_inv_mask;
                        o_out_tvalid <= 1'b1;
                        o_out_tuser  <= r_is_bpsk;
                        // Previous symbol still unaccepted: it is lost
                        if (o_out_tvalid && !i_out_tready) begin
                            o_ovf <= 1'b1;
                        end
                        if (w_last_pld) begin
                            o_out_tlast <= 1'b1;
                            o_pkt_done  <= 1'b1;
                            r_state     <= S_SRCH;
                            r_alt_cnt   <= 8'd0;
                        end else begin
                            r_pld_cnt <= r_pld_cnt + 16'd1;
                        end
                    end
                    default: begin
                        r_state   <= S_SRCH;
                        r_alt_cnt <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_depacketizer.sv
// Directed testbench for depacketizer: one task per scenario, inline checks.
module tb_depacketizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_tdata;
    logic        in_tvalid;
    logic        in_tready;
    logic [7:0]  out_tdata;
    logic        out_tvalid;
    logic        out_tready;
    logic        out_tlast;
    logic        out_tuser;
    logic        hdr_vld;
    logic [15:0] payload_length;
    logic        hdr_err;
    logic        pkt_done;
    logic        ovf;

    int n_tests = 0;
    int n_fail  = 0;

    // Event counters filled by the monitor, cleared at the start of each scenario
    int n_vld, n_err, n_done, n_done_bad, n_out, n_last;
    logic [7:0] cap_data [0:63];
    logic       cap_user [0:63];
    logic       cap_last [0:63];

    localparam logic [7:0] MOD_BPSK = 8'b1010_1010;
    localparam logic [7:0] MOD_QPSK = 8'b0101_0101;
    localparam logic [7:0] MOD_AMB  = 8'b1010_0101;  // exactly 4 of 8 match BPSK

    always #5 clk = ~clk;

    depacketizer #(
        .BYTES(1), .SYNC_MIN(64), .MAX_LEN(4096), .TIMEOUT(1023)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_tdata(in_tdata), .i_in_tvalid(in_tvalid), .o_in_tready(in_tready),
        .o_out_tdata(out_tdata), .o_out_tvalid(out_tvalid), .i_out_tready(out_tready),
        .o_out_tlast(out_tlast), .o_out_tuser(out_tuser),
        .o_hdr_vld(hdr_vld), .o_payload_length(payload_length),
        .o_hdr_err(hdr_err), .o_pkt_done(pkt_done), .o_ovf(ovf)
    );

    // Monitor on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (hdr_vld) n_vld++;
            if (hdr_err) n_err++;
            if (pkt_done) begin
                n_done++;
                if (!(out_tvalid && out_tlast)) n_done_bad++;
            end
            if (out_tvalid && out_tlast) n_last++;
            if (out_tvalid && out_tready) begin
                if (n_out < 64) begin
                    cap_data[n_out] = out_tdata;
                    cap_user[n_out] = out_tuser;
                    cap_last[n_out] = out_tlast;
                end
                n_out++;
            end
        end
    end

    // Run-time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        n_vld = 0; n_err = 0; n_done = 0; n_done_bad = 0; n_out = 0; n_last = 0;
    endtask

    task automatic send_sym(input logic [7:0] d);
        in_tdata  = d;
        in_tvalid = 1'b1;
        @(posedge clk); #1;
        in_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_header(input logic [7:0] mod, input logic [15:0] len, input logic inv);
        for (int i = 0; i < 224; i++) send_sym({7'd0, i[0] ^ inv});
        for (int i = 0; i < 32; i++)  send_sym({7'd0, ~i[0] ^ inv});
        for (int i = 0; i < 8; i++)   send_sym({7'd0, mod[7-i] ^ inv});
        for (int i = 0; i < 16; i++)  send_sym({7'd0, len[15-i] ^ inv});
        for (int i = 0; i < 40; i++)  send_sym({7'd0, i[0] ^ inv});
    endtask

    task automatic send_payload(input logic [7:0] base, input int n, input logic inv);
        for (int i = 0; i < n; i++) send_sym((base + 8'(i)) ^ {8{inv}});
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_tvalid = 1'b0; in_tdata = 8'd0; out_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (in_tready !== 1'b0) begin n_fail++; $display("FAIL rst_in_tready: got %b want 0", in_tready); end
        n_tests++; if (out_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_out_tvalid: got %b want 0", out_tvalid); end
        n_tests++; if (payload_length !== 16'd0) begin n_fail++; $display("FAIL rst_len: got %0d want 0", payload_length); end
        n_tests++; if ({hdr_vld, hdr_err, pkt_done, ovf, out_tlast} !== 5'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 00000", {hdr_vld, hdr_err, pkt_done, ovf, out_tlast}); end
        rst_n = 1'b1;
        idle(2);
        n_tests++; if (in_tready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_tready: got %b want 1", in_tready); end
    endtask

    task automatic test_bpsk_basic();
        clear_mon();
        send_header(MOD_BPSK, 16'd16, 1'b0);
        send_payload(8'hA5, 16, 1'b0);
        idle(4);
        n_tests++; if (n_vld !== 1) begin n_fail++; $display("FAIL bpsk_hdr_vld: got %0d want 1", n_vld); end
        n_tests++; if (payload_length !== 16'd16) begin n_fail++; $display("FAIL bpsk_len: got %0d want 16", payload_length); end
        n_tests++; if (n_out !== 16) begin n_fail++; $display("FAIL bpsk_nout: got %0d want 16", n_out); end
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (cap_data[i] !== 8'hA5 + 8'(i)) begin n_fail++; $display("FAIL bpsk_data[%0d]: got %h want %h", i, cap_data[i], 8'hA5 + 8'(i)); end
            n_tests++; if (cap_user[i] !== 1'b1) begin n_fail++; $display("FAIL bpsk_tuser[%0d]: got %b want 1", i, cap_user[i]); end
        end
        n_tests++; if (cap_last[15] !== 1'b1) begin n_fail++; $display("FAIL bpsk_tlast16: got %b want 1", cap_last[15]); end
        n_tests++; if (n_last !== 1) begin n_fail++; $display("FAIL bpsk_nlast: got %0d want 1", n_last); end
        n_tests++; if (n_done !== 1 || n_done_bad !== 0) begin n_fail++; $display("FAIL bpsk_pkt_done: got %0d/%0d want 1/0", n_done, n_done_bad); end
        n_tests++; if (n_err !== 0) begin n_fail++; $display("FAIL bpsk_err: got %0d want 0", n_err); end
    endtask

    task automatic test_qpsk();
        clear_mon();
        send_header(MOD_QPSK, 16'd10, 1'b0);
        send_payload(8'h10, 5, 1'b0);
        idle(4);
        n_tests++; if (n_vld !== 1) begin n_fail++; $display("FAIL qpsk_hdr_vld: got %0d want 1", n_vld); end
        n_tests++; if (payload_length !== 16'd10) begin n_fail++; $display("FAIL qpsk_len: got %0d want 10", payload_length); end
        n_tests++; if (n_out !== 5) begin n_fail++; $display("FAIL qpsk_nout: got %0d want 5", n_out); end
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (cap_data[i] !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL qpsk_data[%0d]: got %h want %h", i, cap_data[i], 8'h10 + 8'(i)); end
            n_tests++; if (cap_user[i] !== 1'b0) begin n_fail++; $display("FAIL qpsk_tuser[%0d]: got %b want 0", i, cap_user[i]); end
        end
        n_tests++; if (cap_last[4] !== 1'b1 || n_last !== 1) begin n_fail++; $display("FAIL qpsk_tlast: got %b/%0d want 1/1", cap_last[4], n_last); end
        n_tests++; if (n_done !== 1 || n_done_bad !== 0) begin n_fail++; $display("FAIL qpsk_pkt_done: got %0d/%0d want 1/0", n_done, n_done_bad); end
    endtask

    task automatic test_short_preamble();
        clear_mon();
        send_sym(8'd0); send_sym(8'd0);
        for (int i = 0; i < 40; i++) send_sym({7'd0, i[0]});
        for (int i = 0; i < 32; i++) send_sym({7'd0, ~i[0]});
        idle(4);
        n_tests++; if (n_vld !== 0 || n_out !== 0) begin n_fail++; $display("FAIL short_pre_nolock: got vld=%0d out=%0d want 0/0", n_vld, n_out); end
        n_tests++; if (n_err !== 0) begin n_fail++; $display("FAIL short_pre_err: got %0d want 0", n_err); end
        send_header(MOD_BPSK, 16'd4, 1'b0);
        send_payload(8'h70, 4, 1'b0);
        idle(4);
        n_tests++; if (n_vld !== 1 || n_out !== 4) begin n_fail++; $display("FAIL short_pre_relock: got vld=%0d out=%0d want 1/4", n_vld, n_out); end
        n_tests++; if (cap_data[3] !== 8'h73 || cap_last[3] !== 1'b1) begin n_fail++; $display("FAIL short_pre_last: got %h/%b want 73/1", cap_data[3], cap_last[3]); end
    endtask

    task automatic test_mod_err();
        clear_mon();
        send_header(MOD_AMB, 16'd16, 1'b0);
        idle(4);
        n_tests++; if (n_err !== 1) begin n_fail++; $display("FAIL mod_err_pulse: got %0d want 1", n_err); end
        n_tests++; if (n_vld !== 0 || n_out !== 0) begin n_fail++; $display("FAIL mod_err_quiet: got vld=%0d out=%0d want 0/0", n_vld, n_out); end
        send_header(MOD_BPSK, 16'd8, 1'b0);
        send_payload(8'h20, 8, 1'b0);
        idle(4);
        n_tests++; if (n_vld !== 1 || n_out !== 8 || n_last !== 1) begin n_fail++; $display("FAIL mod_err_next: got vld=%0d out=%0d last=%0d want 1/8/1", n_vld, n_out, n_last); end
        n_tests++; if (payload_length !== 16'd8) begin n_fail++; $display("FAIL mod_err_len: got %0d want 8", payload_length); end
    endtask

    task automatic test_len_zero();
        clear_mon();
        send_header(MOD_BPSK, 16'd0, 1'b0);
        idle(4);
        n_tests++; if (n_err !== 1 || n_vld !== 0) begin n_fail++; $display("FAIL len0: got err=%0d vld=%0d want 1/0", n_err, n_vld); end
        n_tests++; if (payload_length !== 16'd8) begin n_fail++; $display("FAIL len0_hold: got %0d want 8", payload_length); end
        send_header(MOD_QPSK, 16'd6, 1'b0);
        send_payload(8'h30, 3, 1'b0);
        idle(4);
        n_tests++; if (n_vld !== 1 || n_out !== 3 || cap_last[2] !== 1'b1) begin n_fail++; $display("FAIL len0_next: got vld=%0d out=%0d last=%b want 1/3/1", n_vld, n_out, cap_last[2]); end
    endtask

    task automatic test_max_len();
        clear_mon();
        send_header(MOD_BPSK, 16'd4097, 1'b0);
        idle(4);
        n_tests++; if (n_err !== 1 || n_vld !== 0) begin n_fail++; $display("FAIL len_4097: got err=%0d vld=%0d want 1/0", n_err, n_vld); end
        clear_mon();
        send_header(MOD_QPSK, 16'd1, 1'b0);
        idle(4);
        n_tests++; if (n_err !== 1) begin n_fail++; $display("FAIL qpsk_len1_err: got %0d want 1", n_err); end
    endtask

    task automatic test_len_one();
        clear_mon();
        send_header(MOD_BPSK, 16'd1, 1'b0);
        send_payload(8'h5E, 1, 1'b0);
        idle(4);
        n_tests++; if (n_out !== 1 || cap_last[0] !== 1'b1 || cap_data[0] !== 8'h5E) begin n_fail++; $display("FAIL len1: got out=%0d last=%b data=%h want 1/1/5e", n_out, cap_last[0], cap_data[0]); end
        n_tests++; if (n_done !== 1 || n_done_bad !== 0) begin n_fail++; $display("FAIL len1_done: got %0d/%0d want 1/0", n_done, n_done_bad); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_header(MOD_QPSK, 16'd4, 1'b0);
        send_payload(8'h40, 2, 1'b0);
        send_header(MOD_BPSK, 16'd3, 1'b0);
        send_payload(8'h50, 3, 1'b0);
        idle(4);
        n_tests++; if (n_vld !== 2 || n_out !== 5 || n_last !== 2) begin n_fail++; $display("FAIL b2b_counts: got vld=%0d out=%0d last=%0d want 2/5/2", n_vld, n_out, n_last); end
        n_tests++; if (cap_last[1] !== 1'b1 || cap_user[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_pkt1: got last=%b user=%b want 1/0", cap_last[1], cap_user[1]); end
        n_tests++; if (cap_data[4] !== 8'h52 || cap_user[4] !== 1'b1 || cap_last[4] !== 1'b1) begin n_fail++; $display("FAIL b2b_pkt2: got %h/%b/%b want 52/1/1", cap_data[4], cap_user[4], cap_last[4]); end
        n_tests++; if (payload_length !== 16'd3) begin n_fail++; $display("FAIL b2b_len: got %0d want 3", payload_length); end
    endtask

    task automatic test_timeout();
        clear_mon();
        send_header(MOD_BPSK, 16'd16, 1'b0);
        send_payload(8'h60, 5, 1'b0);
        idle(1020);
        n_tests++; if (n_err !== 0) begin n_fail++; $display("FAIL timeout_early: got %0d want 0", n_err); end
        idle(10);
        n_tests++; if (n_err !== 1) begin n_fail++; $display("FAIL timeout_err: got %0d want 1", n_err); end
        n_tests++; if (n_out !== 5 || n_last !== 0 || n_done !== 0) begin n_fail++; $display("FAIL timeout_partial: got out=%0d last=%0d done=%0d want 5/0/0", n_out, n_last, n_done); end
    endtask

    task automatic test_reset_mid_payload();
        clear_mon();
        send_header(MOD_BPSK, 16'd4096, 1'b0);
        send_payload(8'h80, 3, 1'b0);
        n_tests++; if (out_tvalid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b want 1", out_tvalid); end
        n_tests++; if (n_vld !== 1 || payload_length !== 16'd4096) begin n_fail++; $display("FAIL len_4096: got vld=%0d len=%0d want 1/4096", n_vld, payload_length); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_tvalid !== 1'b0 || in_tready !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got tvalid=%b tready=%b want 0/0", out_tvalid, in_tready); end
        idle(2);
        rst_n = 1'b1;
        idle(2);
        n_tests++; if (n_last !== 0 || payload_length !== 16'd0) begin n_fail++; $display("FAIL midrst_after: got last=%0d len=%0d want 0/0", n_last, payload_length); end
    endtask

    task automatic test_inverted();
        clear_mon();
        send_header(MOD_BPSK, 16'd8, 1'b1);
        send_payload(8'h3C, 8, 1'b1);
        idle(4);
`ifdef POLARITY_AUTO_EN
        n_tests++; if (n_vld !== 1 || payload_length !== 16'd8) begin n_fail++; $display("FAIL inv_lock: got vld=%0d len=%0d want 1/8", n_vld, payload_length); end
        n_tests++; if (n_out !== 8 || cap_last[7] !== 1'b1) begin n_fail++; $display("FAIL inv_out: got out=%0d last=%b want 8/1", n_out, cap_last[7]); end
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (cap_data[i] !== 8'h3C + 8'(i)) begin n_fail++; $display("FAIL inv_data[%0d]: got %h want %h", i, cap_data[i], 8'h3C + 8'(i)); end
        end
`else
        n_tests++; if (n_vld !== 0 || n_out !== 0) begin n_fail++; $display("FAIL inv_nolock: got vld=%0d out=%0d want 0/0", n_vld, n_out); end
`endif
    endtask

    task automatic test_ovf();
        clear_mon();
        out_tready = 1'b0;
        send_header(MOD_BPSK, 16'd4, 1'b0);
        send_payload(8'h90, 4, 1'b0);
        idle(2);
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", ovf); end
        n_tests++; if (n_out !== 0 || n_done !== 1) begin n_fail++; $display("FAIL ovf_counts: got out=%0d done=%0d want 0/1", n_out, n_done); end
        out_tready = 1'b1;
        send_header(MOD_BPSK, 16'd2, 1'b0);
        send_payload(8'hB0, 2, 1'b0);
        idle(2);
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", ovf); end
        n_tests++; if (n_vld !== 2 || n_out !== 2 || cap_data[1] !== 8'hB1) begin n_fail++; $display("FAIL ovf_next: got vld=%0d out=%0d data=%h want 2/2/b1", n_vld, n_out, cap_data[1]); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_bpsk_basic();
        test_qpsk();
        test_short_preamble();
        test_mod_err();
        test_len_zero();
        test_max_len();
        test_len_one();
        test_back_to_back();
        test_timeout();
        test_reset_mid_payload();
        test_inverted();
        test_ovf();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
